// File: rtl/alu_pkg.sv
// Shared definitions for the sequential integer ALU.
// Holds the operation codes, the controller state type and a
// width-generic rotate helper used by the single-cycle datapath.
package alu_pkg;

    // Bit 5 of the function code selects the float path, which this ALU rejects
    localparam int unsigned FC_FLOAT_BIT = 5;

    localparam logic [4:0] FC_ADD  = 5'b00000;
    localparam logic [4:0] FC_SUB  = 5'b00001;
    localparam logic [4:0] FC_MUL  = 5'b00010;
    localparam logic [4:0] FC_SQRT = 5'b00011;
    localparam logic [4:0] FC_DIV  = 5'b00100;
    localparam logic [4:0] FC_MOD  = 5'b00101;
    localparam logic [4:0] FC_SHL  = 5'b00110;
    localparam logic [4:0] FC_SHR  = 5'b00111;
    localparam logic [4:0] FC_ROTL = 5'b01000;
    localparam logic [4:0] FC_ROTR = 5'b01001;
    localparam logic [4:0] FC_EQ   = 5'b10000;
    localparam logic [4:0] FC_NE   = 5'b10001;
    localparam logic [4:0] FC_GTU  = 5'b10010;
    localparam logic [4:0] FC_GEU  = 5'b10011;
    localparam logic [4:0] FC_LTU  = 5'b10100;
    localparam logic [4:0] FC_LEU  = 5'b10101;
    localparam logic [4:0] FC_GTS  = 5'b10110;
    localparam logic [4:0] FC_LTS  = 5'b10111;
    localparam logic [4:0] FC_NOT  = 5'b11000;
    localparam logic [4:0] FC_AND  = 5'b11001;
    localparam logic [4:0] FC_OR   = 5'b11010;
    localparam logic [4:0] FC_XOR  = 5'b11011;
    localparam logic [4:0] FC_XNOR = 5'b11100;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DIV_LAUF    = 2'd1,
        DIV_KORR    = 2'd2,
        WURZEL_LAUF = 2'd3
    } state_t;

    // Largest operand width the rotate helper supports
    localparam int unsigned ROT_MAX = 128;

    // Rotates the low 'width' bits of val by amt (amt < width).
    // The caller passes a constant width, so the loop folds into a plain
    // bit permutation selected by amt.
    function automatic logic [ROT_MAX-1:0] rotate(
        input logic [ROT_MAX-1:0] val,
        input int unsigned        amt,
        input int unsigned        width,
        input logic               left
    );
        logic [ROT_MAX-1:0] res;
        int unsigned        dst;
        res = '0;
        for (int unsigned i = 0; i < ROT_MAX; i++) begin
            if (i < width) begin
                dst = left ? (i + amt) : (i + width - amt);
                if (dst >= width) begin
                    dst = dst - width;
                end
                res[dst] = val[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_dividierer.sv
// Signed restoring divider.
// start  : latches |dividend|, |divisor| and the sign bits
// last   : high during the final of WIDTH shift/subtract cycles
// quotient/remainder : sign-corrected results, valid once the final step
//                      has been clocked and held until the next start
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// The divisor must be nonzero; the caller handles division by zero.
module alu_dividierer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rest;
    logic [WIDTH-1:0] betrag_divisor;
    logic [CW-1:0]    cnt;
    logic             laeuft;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] betrag_a;
    logic [WIDTH-1:0] betrag_b;
    logic [WIDTH:0]   geschoben;
    logic [WIDTH:0]   differenz;
    logic             passt;

    // Magnitude of the most negative value is 2^(WIDTH-1), still exact unsigned
    assign betrag_a = dividend[WIDTH-1] ? -dividend : dividend;
    assign betrag_b = divisor[WIDTH-1]  ? -divisor  : divisor;

    // Partial remainder extended by the next dividend bit (MSB first)
    assign geschoben = {rest, quo[WIDTH-1]};
    assign differenz = geschoben - {1'b0, betrag_divisor};
    assign passt     = geschoben >= {1'b0, betrag_divisor};

    assign last = laeuft && (cnt == CW'(WIDTH - 1));

    assign quotient  = neg_q ? -quo  : quo;
    assign remainder = neg_r ? -rest : rest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo            <= '0;
            rest           <= '0;
            betrag_divisor <= '0;
            cnt            <= '0;
            laeuft         <= 1'b0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
        end else if (start) begin
            quo            <= betrag_a;
            rest           <= '0;
            betrag_divisor <= betrag_b;
            cnt            <= '0;
            laeuft         <= 1'b1;
            neg_q          <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r          <= dividend[WIDTH-1];
        end else if (laeuft) begin
            // Quotient bits shift in where dividend bits shift out
            rest <= passt ? differenz[WIDTH-1:0] : geschoben[WIDTH-1:0];
            quo  <= {quo[WIDTH-2:0], passt};
            cnt  <= cnt + 1'b1;
            if (last) begin
                laeuft <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_sequenziell.sv
// Sequential integer ALU with a valid/ready request handshake.
// Clock, Reset        : clock (rising edge), asynchronous active-high reset
// Daten1, Daten2      : operands A and B
// FunktionsCode       : operation select; bit 5 (float path) is rejected
// StartSignal, Bereit : request valid / ready, accepted when both are high
// Fertig              : one-cycle pulse marking Ergebnis/Fehler as valid
// Ergebnis, Fehler    : result and error flag, held until the next Fertig
// Single-cycle ops finish at the acceptance edge; div/mod take WIDTH+1
// cycles via alu_dividierer, sqrt takes WIDTH/2 cycles in this module.
module alu_sequenziell
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Daten1,
    input  logic [WIDTH-1:0] Daten2,
    input  logic [5:0]       FunktionsCode,
    input  logic             StartSignal,
    output logic             Bereit,
    output logic             Fertig,
    output logic [WIDTH-1:0] Ergebnis,
    output logic             Fehler
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int HALB = WIDTH / 2;
    // Sqrt partial remainder stays below 2^(HALB+1); two more bits shift in per step
    localparam int RW   = HALB + 3;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] ergebnis_next;
    logic             fertig_next;
    logic             fehler_next;
    logic             div_start;
    logic             sq_start;
    logic             ist_mod;
    logic             ist_mod_next;

    logic             div_last;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;

    logic [WIDTH-1:0] einzel_erg;
    logic             einzel_ok;
    logic [ROT_MAX-1:0] rot_links;
    logic [ROT_MAX-1:0] rot_rechts;

    logic [WIDTH-1:0] sq_x;
    logic [HALB-1:0]  sq_root;
    logic [RW-1:0]    sq_rem;
    logic [SHW-1:0]   sq_cnt;
    logic [RW-1:0]    sq_rem_sh;
    logic [RW-1:0]    sq_trial;
    logic             sq_passt;
    logic [RW-1:0]    sq_rem_n;
    logic [HALB-1:0]  sq_root_n;
    logic             sq_last;

    assign Bereit = (state == IDLE);

    alu_dividierer #(
        .WIDTH(WIDTH)
    ) u_dividierer (
        .clk       (Clock),
        .rst       (Reset),
        .start     (div_start),
        .dividend  (Daten1),
        .divisor   (Daten2),
        .last      (div_last),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    assign rot_links  = rotate(ROT_MAX'(Daten1), 32'(Daten2[SHW-1:0]), WIDTH, 1'b1);
    assign rot_rechts = rotate(ROT_MAX'(Daten1), 32'(Daten2[SHW-1:0]), WIDTH, 1'b0);

    always_comb begin
        einzel_erg = '0;
        einzel_ok  = 1'b1;
        case (FunktionsCode[4:0])
            FC_ADD:  einzel_erg = Daten1 + Daten2;
            FC_SUB:  einzel_erg = Daten1 - Daten2;
            FC_MUL:  einzel_erg = Daten1 * Daten2;
            // Full-width amount: anything >= WIDTH clears the result
            FC_SHL:  einzel_erg = (Daten2 >= WIDTH'(WIDTH)) ? '0 : (Daten1 << Daten2[SHW-1:0]);
            FC_SHR:  einzel_erg = (Daten2 >= WIDTH'(WIDTH)) ? '0 : (Daten1 >> Daten2[SHW-1:0]);
            FC_ROTL: einzel_erg = rot_links[WIDTH-1:0];
            FC_ROTR: einzel_erg = rot_rechts[WIDTH-1:0];
            FC_EQ:   einzel_erg = WIDTH'(Daten1 == Daten2);
            FC_NE:   einzel_erg = WIDTH'(Daten1 != Daten2);
            FC_GTU:  einzel_erg = WIDTH'(Daten1 >  Daten2);
            FC_GEU:  einzel_erg = WIDTH'(Daten1 >= Daten2);
            FC_LTU:  einzel_erg = WIDTH'(Daten1 <  Daten2);
            FC_LEU:  einzel_erg = WIDTH'(Daten1 <= Daten2);
            FC_GTS:  einzel_erg = WIDTH'($signed(Daten1) > $signed(Daten2));
            FC_LTS:  einzel_erg = WIDTH'($signed(Daten1) < $signed(Daten2));
            FC_NOT:  einzel_erg = ~Daten1;
            FC_AND:  einzel_erg = Daten1 & Daten2;
            FC_OR:   einzel_erg = Daten1 | Daten2;
            FC_XOR:  einzel_erg = Daten1 ^ Daten2;
            FC_XNOR: einzel_erg = ~(Daten1 ^ Daten2);
            default: einzel_ok  = 1'b0;
        endcase
    end

    // One digit-by-digit sqrt step: bring down two radicand bits, try 4*root+1
    assign sq_rem_sh = {sq_rem[RW-3:0], sq_x[WIDTH-1:WIDTH-2]};
    assign sq_trial  = {1'b0, sq_root, 2'b01};
    assign sq_passt  = sq_rem_sh >= sq_trial;
    assign sq_rem_n  = sq_passt ? (sq_rem_sh - sq_trial) : sq_rem_sh;
    assign sq_root_n = {sq_root[HALB-2:0], sq_passt};
    assign sq_last   = (state == WURZEL_LAUF) && (sq_cnt == SHW'(HALB - 1));

    always_comb begin
        state_next    = state;
        ergebnis_next = Ergebnis;
        fertig_next   = 1'b0;
        fehler_next   = Fehler;
        div_start     = 1'b0;
        sq_start      = 1'b0;
        ist_mod_next  = ist_mod;
        case (state)
            IDLE: begin
                if (StartSignal) begin
                    if (FunktionsCode[FC_FLOAT_BIT]) begin
                        ergebnis_next = '0;
                        fertig_next   = 1'b1;
                        fehler_next   = 1'b1;
                    end else if (FunktionsCode[4:0] == FC_DIV || FunktionsCode[4:0] == FC_MOD) begin
                        if (Daten2 == '0) begin
                            ergebnis_next = (FunktionsCode[4:0] == FC_DIV) ? '1 : Daten1;
                            fertig_next   = 1'b1;
                            fehler_next   = 1'b1;
                        end else begin
                            div_start    = 1'b1;
                            ist_mod_next = (FunktionsCode[4:0] == FC_MOD);
                            state_next   = DIV_LAUF;
                        end
                    end else if (FunktionsCode[4:0] == FC_SQRT) begin
                        sq_start   = 1'b1;
                        state_next = WURZEL_LAUF;
                    end else begin
                        ergebnis_next = einzel_ok ? einzel_erg : '0;
                        fertig_next   = 1'b1;
                        fehler_next   = ~einzel_ok;
                    end
                end
            end
            DIV_LAUF: begin
                if (div_last) begin
                    state_next = DIV_KORR;
                end
            end
            DIV_KORR: begin
                ergebnis_next = ist_mod ? div_remainder : div_quotient;
                fertig_next   = 1'b1;
                fehler_next   = 1'b0;
                state_next    = IDLE;
            end
            WURZEL_LAUF: begin
                // The final step's root goes straight to the output at the same edge
                if (sq_last) begin
                    ergebnis_next = {{HALB{1'b0}}, sq_root_n};
                    fertig_next   = 1'b1;
                    fehler_next   = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Ergebnis <= '0;
            Fertig   <= 1'b0;
            Fehler   <= 1'b0;
            ist_mod  <= 1'b0;
        end else begin
            Ergebnis <= ergebnis_next;
            Fertig   <= fertig_next;
            Fehler   <= fehler_next;
            ist_mod  <= ist_mod_next;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sq_x    <= '0;
            sq_root <= '0;
            sq_rem  <= '0;
            sq_cnt  <= '0;
        end else if (sq_start) begin
            sq_x    <= Daten1;
            sq_root <= '0;
            sq_rem  <= '0;
            sq_cnt  <= '0;
        end else if (state == WURZEL_LAUF) begin
            sq_x    <= {sq_x[WIDTH-3:0], 2'b00};
            sq_root <= sq_root_n;
            sq_rem  <= sq_rem_n;
            sq_cnt  <= sq_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_sequenziell.sv
module tb_alu_sequenziell;

    localparam int W = 32;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [W-1:0]  Daten1 = '0;
    logic [W-1:0]  Daten2 = '0;
    logic [5:0]    FunktionsCode = '0;
    logic          StartSignal = 1'b0;
    logic          Bereit;
    logic          Fertig;
    logic [W-1:0]  Ergebnis;
    logic          Fehler;

    alu_sequenziell #(.WIDTH(W)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Daten1        (Daten1),
        .Daten2        (Daten2),
        .FunktionsCode (FunktionsCode),
        .StartSignal   (StartSignal),
        .Bereit        (Bereit),
        .Fertig        (Fertig),
        .Ergebnis      (Ergebnis),
        .Fehler        (Fehler)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] erg;
        logic         fehl;
        int unsigned  edge_no;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned busy_from = 0;
    int unsigned busy_until = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Reference model: plain 64-bit arithmetic on the operation rules
    function automatic void model(input logic [5:0] fc, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e, output int unsigned off);
        longint      sa;
        longint      sb_;
        longint      q;
        logic [63:0] t;
        int unsigned k;
        logic [W-1:0] c;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        r = '0; e = 1'b0; off = 0;
        if (fc[5]) begin
            e = 1'b1;
            return;
        end
        case (fc[4:0])
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a * b;
            5'd3: begin
                for (int i = 15; i >= 0; i--) begin
                    c = r | (32'd1 << i);
                    if (longint'(c) * longint'(c) <= longint'({32'd0, a})) r = c;
                end
                off = 16;
            end
            5'd4, 5'd5: begin
                if (b == 0) begin
                    e = 1'b1;
                    r = (fc[4:0] == 5'd4) ? 32'hFFFF_FFFF : a;
                end else begin
                    q = (fc[4:0] == 5'd4) ? (sa / sb_) : (sa % sb_);
                    r = q[31:0];
                    off = 33;
                end
            end
            5'd6:  r = (b >= 32) ? 32'd0 : (a << b);
            5'd7:  r = (b >= 32) ? 32'd0 : (a >> b);
            5'd8, 5'd9: begin
                k = b % 32;
                if (fc[0]) k = (32 - k) % 32;
                t = {a, a} << k;
                r = t[63:32];
            end
            5'd16: r = {31'd0, a == b};
            5'd17: r = {31'd0, a != b};
            5'd18: r = {31'd0, a > b};
            5'd19: r = {31'd0, a >= b};
            5'd20: r = {31'd0, a < b};
            5'd21: r = {31'd0, a <= b};
            5'd22: r = {31'd0, sa > sb_};
            5'd23: r = {31'd0, sa < sb_};
            5'd24: r = ~a;
            5'd25: r = a & b;
            5'd26: r = a | b;
            5'd27: r = a ^ b;
            5'd28: r = ~(a ^ b);
            default: e = 1'b1;
        endcase
    endfunction

    // Monitor: checks Bereit every cycle and pops the scoreboard on each Fertig
    always @(negedge Clock) begin
        if (!Reset) begin
            vectors++;
            if (Bereit !== !(cyc >= busy_from && cyc < busy_until)) begin
                miscompares++;
                $display("FAIL bereit cyc=%0d got=%b want=%b", cyc, Bereit, !Bereit);
            end
            if (Fertig === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_fertig cyc=%0d erg=%h", cyc, Ergebnis);
                end else begin
                    if (Ergebnis !== sb[0].erg || Fehler !== sb[0].fehl || cyc != sb[0].edge_no) begin
                        miscompares++;
                        $display("FAIL result cyc=%0d got erg=%h fehler=%b, want erg=%h fehler=%b at cyc=%0d",
                                 cyc, Ergebnis, Fehler, sb[0].erg, sb[0].fehl, sb[0].edge_no);
                    end
                    void'(sb.pop_front());
                end
            end else if (Fertig !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL fertig_x cyc=%0d got=%b want=0/1", cyc, Fertig);
            end else if (sb.size() > 0 && cyc > sb[0].edge_no) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_fertig cyc=%0d got none, want erg=%h at cyc=%0d",
                         cyc, sb[0].erg, sb[0].edge_no);
                void'(sb.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Called at a negedge; returns at a later negedge
    task automatic issue(input logic [5:0] fc, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e_erg, input logic e_f, input int unsigned off);
        int unsigned n = 0;
        while (Bereit !== 1'b1 && n < 300) begin
            @(negedge Clock);
            n++;
        end
        if (Bereit !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL bereit_timeout got=%b want=1", Bereit);
        end
        FunktionsCode = fc;
        Daten1 = a;
        Daten2 = b;
        StartSignal = 1'b1;
        sb.push_back('{e_erg, e_f, cyc + 1 + off});
        if (off > 0) begin
            busy_from = cyc + 1;
            busy_until = cyc + 1 + off;
        end
        @(negedge Clock);
        // Scramble inputs after acceptance: results must come from latched operands
        StartSignal = 1'b0;
        Daten1 = $urandom;
        Daten2 = $urandom;
        FunktionsCode = 6'($urandom);
    endtask

    task automatic issue_m(input logic [5:0] fc, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         e;
        int unsigned  off;
        model(fc, a, b, r, e, off);
        issue(fc, a, b, r, e, off);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5, 6: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    int codes[23] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28};

    initial begin
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("reset_bereit", 32'(Bereit), 32'd1);
        chk("reset_fertig", 32'(Fertig), 32'd0);
        chk("reset_ergebnis", Ergebnis, 32'd0);
        chk("reset_fehler", 32'(Fehler), 32'd0);

        // Directed cases with hand-computed expectations
        issue(6'h00, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 0);
        issue(6'h1B, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 0);
        issue(6'h04, -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        issue(6'h05, -32'sd7, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        issue(6'h04, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
        issue(6'h05, 32'd5, 32'd0, 32'd5, 1'b1, 0);
        issue(6'h04, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
        issue(6'h05, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        issue(6'h03, 32'd1000000, 32'd0, 32'd1000, 1'b0, 16);
        // Requests while busy must be dropped without a Fertig
        for (int i = 0; i < 5; i++) begin
            FunktionsCode = 6'h00;
            Daten1 = 32'd1;
            Daten2 = 32'd1;
            StartSignal = 1'b1;
            @(negedge Clock);
        end
        StartSignal = 1'b0;
        issue(6'h03, 32'hFFFF_FFFF, 32'd0, 32'd65535, 1'b0, 16);
        issue(6'h09, 32'd1, 32'd33, 32'h8000_0000, 1'b0, 0);
        issue(6'h06, 32'd1, 32'd32, 32'd0, 1'b0, 0);
        issue(6'h16, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
        issue(6'h12, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
        issue(6'h20, 32'd3, 32'd4, 32'd0, 1'b1, 0);
        issue(6'h0A, 32'd3, 32'd4, 32'd0, 1'b1, 0);

        // Reset 10 cycles into a division aborts it silently
        issue(6'h04, 32'd1000, 32'd7, 32'd142, 1'b0, 33);
        repeat (9) @(negedge Clock);
        @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        chk("abort_bereit", 32'(Bereit), 32'd1);
        chk("abort_fertig", 32'(Fertig), 32'd0);
        chk("abort_ergebnis", Ergebnis, 32'd0);
        chk("abort_fehler", 32'(Fehler), 32'd0);
        sb.delete();
        busy_from = 0;
        busy_until = 0;
        @(negedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        issue(6'h00, 32'd2, 32'd3, 32'd5, 1'b0, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [5:0] fc;
            if ($urandom_range(0, 9) == 0) fc = 6'($urandom);
            else fc = 6'(codes[$urandom_range(0, 22)]);
            issue_m(fc, pick(), pick());
            if ($urandom_range(0, 3) == 0) @(negedge Clock);
        end

        for (int n = 0; n < 200 && sb.size() > 0; n++) @(negedge Clock);
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
